// File: rtl/fmc_transmitter_pkg.sv
// fmc_transmitter_pkg: shared image geometry, link group layout and transmitter state encoding
package fmc_transmitter_pkg;
    localparam int COORD_WIDTH   = 12;
    localparam int IMAGE_WIDTH   = 640;
    localparam int IMAGE_HEIGHT  = 480;
    localparam int CAM_GROUP_W   = 24;
    localparam int PIX_PER_GROUP = 3;
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_SETUP  = 3'd1,
        TX_ACTIVE = 3'd2,
        TX_LBLANK = 3'd3,
        TX_FBLANK = 3'd4
    } tx_state_t;
endpackage

// File: rtl/fmc_transmitter_if.sv
// fmc_transmitter_if: pixel handshake, frame control and FMC camera link bundle
interface fmc_transmitter_if;
    import fmc_transmitter_pkg::*;
    logic                   i_frame_start;
    logic                   i_pix_valid;
    logic [7:0]             i_pix_data;
    logic                   o_pix_ready;
    logic [CAM_GROUP_W-1:0] o_cam_data;
    logic                   o_cam_fval;
    logic                   o_cam_lval;
    logic                   o_cam_dval;
    logic                   o_busy;
    logic                   o_frame_done;
    modport master (
        input  i_frame_start, i_pix_valid, i_pix_data,
        output o_pix_ready, o_cam_data, o_cam_fval, o_cam_lval, o_cam_dval, o_busy, o_frame_done
    );
    modport slave (
        output i_frame_start, i_pix_valid, i_pix_data,
        input  o_pix_ready, o_cam_data, o_cam_fval, o_cam_lval, o_cam_dval, o_busy, o_frame_done
    );
endinterface

// File: rtl/fmc_transmitter_packer.sv
// fmc_pixel_packer: collects pixels into three-lane groups, P0 in the low byte, closing early on the line's last pixel
module fmc_pixel_packer
    import fmc_transmitter_pkg::*;
(
    input  logic                   i_cam_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr,
    input  logic                   i_last,
    input  logic [7:0]             i_pix,
    output logic [CAM_GROUP_W-1:0] o_group,
    output logic                   o_valid
);
    logic [CAM_GROUP_W-1:0] acc;
    logic [CAM_GROUP_W-1:0] merged;
    logic [1:0]             lane;
    logic                   close;

    assign merged = acc | (CAM_GROUP_W'(i_pix) << {lane, 3'b000});
    assign close  = i_wr && (lane == 2'(PIX_PER_GROUP - 1) || i_last);

    // accumulator lanes stay zero until written, so a short final group pads with 0
    always_ff @(posedge i_cam_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= '0;
            lane    <= '0;
            o_group <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= close;
            if (close) begin
                o_group <= merged;
                acc     <= '0;
                lane    <= '0;
            end else if (i_wr) begin
                acc  <= merged;
                lane <= lane + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fmc_transmitter.sv
// fmc_transmitter: camera-side FMC link source with setup, line-blank and frame-blank framing
module fmc_transmitter
    import fmc_transmitter_pkg::*;
#(
    parameter int H_RES    = IMAGE_WIDTH,
    parameter int V_RES    = IMAGE_HEIGHT,
    parameter int FV_SETUP = 4,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 32
) (
    input  logic              i_cam_clk,
    input  logic              i_rst_n,
    fmc_transmitter_if.master bus
);
    localparam int CNT_MAX = (FV_SETUP > H_BLANK) ? ((FV_SETUP > V_BLANK) ? FV_SETUP : V_BLANK)
                                                  : ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [2:0] S_IDLE   = 3'(TX_IDLE);
    localparam logic [2:0] S_SETUP  = 3'(TX_SETUP);
    localparam logic [2:0] S_ACTIVE = 3'(TX_ACTIVE);
    localparam logic [2:0] S_LBLANK = 3'(TX_LBLANK);
    localparam logic [2:0] S_FBLANK = 3'(TX_FBLANK);
    localparam logic [COORD_WIDTH-1:0] X_END  = COORD_WIDTH'(H_RES);
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(H_RES - 1);
    localparam logic [COORD_WIDTH-1:0] Y_END  = COORD_WIDTH'(V_RES);
    localparam logic [CNT_W-1:0] SU_END = CNT_W'(FV_SETUP - 1);
    localparam logic [CNT_W-1:0] HB_END = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VB_END = CNT_W'(V_BLANK - 1);

    logic [2:0]             state, state_n;
    logic [COORD_WIDTH-1:0] x, x_n, y, y_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   ready, fval, lval, busy, done, accept;

    assign accept = bus.i_pix_valid & ready;

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        cnt_n   = cnt;
        case (state)
            S_IDLE: if (bus.i_frame_start) begin
                state_n = S_SETUP;
                x_n     = '0;
                y_n     = '0;
                cnt_n   = '0;
            end
            S_SETUP: begin
                cnt_n   = (cnt == SU_END) ? '0 : cnt + 1'b1;
                state_n = (cnt == SU_END) ? S_ACTIVE : S_SETUP;
            end
            // the cycle presenting the final group still belongs to ACTIVE
            S_ACTIVE: begin
                x_n     = x + COORD_WIDTH'(accept);
                state_n = (x == X_END) ? S_LBLANK : S_ACTIVE;
            end
            S_LBLANK: if (cnt == HB_END) begin
                cnt_n   = '0;
                x_n     = '0;
                y_n     = y + 1'b1;
                state_n = (y + 1'b1 < Y_END) ? S_ACTIVE : S_FBLANK;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            S_FBLANK: begin
                cnt_n   = (cnt == VB_END) ? '0 : cnt + 1'b1;
                state_n = (cnt == VB_END) ? S_IDLE : S_FBLANK;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_cam_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            fval  <= 1'b0;
            lval  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            cnt   <= cnt_n;
            ready <= state_n == S_ACTIVE && x_n < X_END;
            fval  <= state_n == S_SETUP || state_n == S_ACTIVE || state_n == S_LBLANK;
            lval  <= state_n == S_ACTIVE;
            busy  <= state_n != S_IDLE;
            done  <= state == S_LBLANK && state_n == S_FBLANK;
        end
    end

    fmc_pixel_packer u_packer (
        .i_cam_clk (i_cam_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (accept),
        .i_last    (x == X_LAST),
        .i_pix     (bus.i_pix_data),
        .o_group   (bus.o_cam_data),
        .o_valid   (bus.o_cam_dval)
    );

    assign bus.o_pix_ready  = ready;
    assign bus.o_cam_fval   = fval;
    assign bus.o_cam_lval   = lval;
    assign bus.o_busy       = busy;
    assign bus.o_frame_done = done;
endmodule
